// File: rtl/mxn_unshift_seq.sv
// Sequential inverse of the packed multi-set shifter: rebuilds one lane per clock
// from captured result/overflow/control words and flags inconsistent lanes.
//
// state | meaning
// IDLE  | ready for a request, in_ready high
// RUN   | decoding lane idx into restored/err, one lane per cycle
// DONE  | result valid, held until res_ready
module mxn_unshift_seq #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2,
  parameter bit OP    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SETS*WIDTH-1:0]   out_packed,
  input  logic [SETS*WIDTH-1:0]   overflow_packed,
  input  logic [SETS*WIDTH-1:0]   shift_packed,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SETS*WIDTH-1:0]   restored_packed,
  output logic [SETS-1:0]         err_packed
);
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int PW    = SETS * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    cap_out_q, cap_out_d;
  logic [PW-1:0]    cap_ovf_q, cap_ovf_d;
  logic [PW-1:0]    cap_sh_q, cap_sh_d;
  logic [PW-1:0]    restored_q, restored_d;
  logic [SETS-1:0]  err_q, err_d;

  logic [WIDTH-1:0] lane_o, lane_v, lane_s, lane_rest, low_mask;
  logic             lane_err, fill_ref;
  int               k_amt;

  always_comb begin
    lane_o = '0;
    lane_v = '0;
    lane_s = '0;
    for (int i = 0; i < SETS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        lane_o = cap_out_q[i*WIDTH +: WIDTH];
        lane_v = cap_ovf_q[i*WIDTH +: WIDTH];
        lane_s = cap_sh_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Lane decode: low_mask covers the k overflow bits that legitimately carry data.
  always_comb begin
    k_amt     = int'(lane_s[WIDTH-2:1]);
    lane_rest = lane_o;
    lane_err  = 1'b0;
    low_mask  = '0;
    fill_ref  = lane_s[WIDTH-1];
    if (k_amt >= WIDTH) begin
      lane_rest = '0;
      lane_err  = 1'b1;
    end else begin
      low_mask = {WIDTH{1'b1}} >> (WIDTH - k_amt);
      if (k_amt != 0) begin
        if (!lane_s[0])
          lane_rest = (lane_o >> k_amt) | (lane_v << (WIDTH - k_amt));
        else
          lane_rest = (lane_o << k_amt) | (lane_v & low_mask);
      end
      if ((lane_v & ~low_mask) != '0)
        lane_err = 1'b1;
      if (lane_s[0] && OP)
        fill_ref = lane_rest[WIDTH-1];
      for (int j = 0; j < WIDTH; j++) begin
        if (!lane_s[0] && (j < k_amt) && (lane_o[j] != fill_ref))
          lane_err = 1'b1;
        if (lane_s[0] && (j >= WIDTH - k_amt) && (lane_o[j] != fill_ref))
          lane_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cap_out_d  = cap_out_q;
    cap_ovf_d  = cap_ovf_q;
    cap_sh_d   = cap_sh_q;
    restored_d = restored_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          cap_out_d = out_packed;
          cap_ovf_d = overflow_packed;
          cap_sh_d  = shift_packed;
          idx_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < SETS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            restored_d[i*WIDTH +: WIDTH] = lane_rest;
            err_d[i]                     = lane_err;
          end
        end
        if (idx_q == IDX_W'(SETS - 1))
          state_d = DONE;
        else
          idx_d = idx_q + IDX_W'(1);
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cap_out_q  <= '0;
      cap_ovf_q  <= '0;
      cap_sh_q   <= '0;
      restored_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cap_out_q  <= cap_out_d;
      cap_ovf_q  <= cap_ovf_d;
      cap_sh_q   <= cap_sh_d;
      restored_q <= restored_d;
      err_q      <= err_d;
    end
  end

  assign restored_packed = restored_q;
  assign err_packed      = err_q;
endmodule

// File: tb/tb_mxn_unshift_seq.sv
// Directed bench for mxn_unshift_seq: logical (OP=0) and arithmetic (OP=1) instances
// driven in lockstep with hand-computed expected results.
module tb_mxn_unshift_seq;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int PW = W * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, res_ready;
  logic [PW-1:0] out_p, ovf_p, sh_p;
  logic          in_ready, res_valid, in_ready_a, res_valid_a;
  logic [PW-1:0] rest, rest_a;
  logic [S-1:0]  err, err_a;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mxn_unshift_seq #(.WIDTH(W), .SETS(S), .OP(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_packed(out_p), .overflow_packed(ovf_p), .shift_packed(sh_p),
    .res_valid(res_valid), .res_ready(res_ready),
    .restored_packed(rest), .err_packed(err)
  );

  mxn_unshift_seq #(.WIDTH(W), .SETS(S), .OP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_packed(out_p), .overflow_packed(ovf_p), .shift_packed(sh_p),
    .res_valid(res_valid_a), .res_ready(res_ready),
    .restored_packed(rest_a), .err_packed(err_a)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bp=1 keeps in_valid asserted through RUN/DONE and stalls res_ready for 5 cycles.
  task automatic run_txn(input logic [PW-1:0] o, input logic [PW-1:0] v,
                         input logic [PW-1:0] s, input logic [PW-1:0] er,
                         input logic [S-1:0] ee, input logic [PW-1:0] era,
                         input logic [S-1:0] eea, input bit bp);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    out_p = o; ovf_p = v; sh_p = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = bp;
    out_p = ~o; ovf_p = ~v; sh_p = ~s;
    chk("in_ready_run", in_ready, 0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, S);
    chk("res_valid_a", res_valid_a, 1);
    chk("restored", rest, er);
    chk("err", err, ee);
    chk("restored_a", rest_a, era);
    chk("err_a", err_a, eea);
    if (bp) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("bp_valid", res_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_restored", rest, er);
        chk("bp_err", err, ee);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("valid_drop", res_valid, 0);
    chk("back_to_idle", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    out_p = '0; ovf_p = '0; sh_p = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_restored", rest, 0);
    chk("post_rst_err", err, 0);

    // lane0 left k=1, lane1 right k=2: both round-trip to 1011
    run_txn(8'hE6, 8'h31, 8'hD2, 8'hBB, 2'b00, 8'hBB, 2'b00, 1'b0);
    // lane0 fill mismatch; lane1 right k=1 fill=1 of 1010
    run_txn(8'hD7, 8'h01, 8'hB2, 8'hAB, 2'b01, 8'hAB, 2'b01, 1'b0);
    // lane0 k=0 passthrough; lane1 right k=1 fill=0: only logical flags it
    run_txn(8'hD5, 8'h00, 8'h30, 8'hA5, 2'b10, 8'hA5, 2'b00, 1'b0);
    // stray overflow: lane0 k=1 ovf bit1, lane1 k=0 ovf nonzero
    run_txn(8'h96, 8'h42, 8'h02, 8'h93, 2'b11, 8'h93, 2'b11, 1'b0);
    // backpressure plus in_valid noise during RUN and DONE
    run_txn(8'hE6, 8'h31, 8'hD2, 8'hBB, 2'b00, 8'hBB, 2'b00, 1'b1);

    // reset one cycle after accept
    @(negedge clk);
    out_p = 8'hD7; ovf_p = 8'h01; sh_p = 8'hB2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_res_valid", res_valid, 0);
    chk("midrun_restored", rest, 0);
    chk("midrun_err", err, 0);
    chk("midrun_restored_a", rest_a, 0);
    chk("midrun_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_release_ready", in_ready, 1);
    run_txn(8'hD5, 8'h00, 8'h30, 8'hA5, 2'b10, 8'hA5, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
